// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: default widths, FSM states, address fields.
package sdram_pkg;

  localparam int unsigned DefAddrWidth = 25;
  localparam int unsigned DefDataWidth = 16;

  // Word address layout seen by the controller; the arbiter passes it through untouched.
  localparam int unsigned BankMsb = 24;
  localparam int unsigned BankLsb = 23;
  localparam int unsigned RowMsb  = 22;
  localparam int unsigned RowLsb  = 10;
  localparam int unsigned ColMsb  = 9;
  localparam int unsigned ColLsb  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRa,
    StRd
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_grant.sv
// Two-way grant logic for the SDRAM port arbiter.
// SDRAM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module sdram_arb_grant (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_valid_i,
  input  logic       accept_i,
  input  logic       owner_i,
  output logic [1:0] grant_o
);

`ifdef SDRAM_ARB_RR_EN
  logic last_grant_q;

  // Starts at 1 so port 0 wins the first contention after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else if (accept_i) begin
      last_grant_q <= owner_i;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    unique case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_i, accept_i, owner_i};

  always_comb begin
    grant_o = 2'b00;
    if (req_valid_i[0]) begin
      grant_o = 2'b01;
    end else if (req_valid_i[1]) begin
      grant_o = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates two client ports onto a single-outstanding AXI slave (burst length 1).
// Build option: SDRAM_ARB_RR_EN enables round-robin arbitration (default fixed priority).
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]              wr_done_o,
  output logic [1:0]              rd_valid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
  output logic                    m_axi_arvalid_o,
  input  logic                    m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
  input  logic                    m_axi_rvalid_i,
  output logic                    m_axi_rready_o
);

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  owner_q;
  logic [1:0]            wr_done_q;
  logic [1:0]            rd_valid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  arvalid_q;
  logic                  rready_q;

  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       sel;

  assign idle   = (state_q == StIdle);
  assign accept = idle && (grant != 2'b00);
  assign sel    = grant[1];

  sdram_arb_grant u_grant (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .accept_i    (accept),
    .owner_i     (sel),
    .grant_o     (grant)
  );

  assign req_ready_o = idle ? grant : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      owner_q    <= 1'b0;
      wr_done_q  <= 2'b00;
      rd_valid_q <= 2'b00;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      wr_done_q  <= 2'b00;
      rd_valid_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= sel ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
            wdata_q <= sel ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
            owner_q <= sel;
            if (req_we_i[sel]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWr;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRa;
            end
          end
        end
        StWr: begin
          // The controller only takes address and data together.
          if (m_axi_awready_i && m_axi_wready_i) begin
            awvalid_q          <= 1'b0;
            wvalid_q           <= 1'b0;
            wr_done_q[owner_q] <= 1'b1;
            state_q            <= StIdle;
          end
        end
        StRa: begin
          if (m_axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRd;
          end
        end
        StRd: begin
          if (m_axi_rvalid_i) begin
            rready_q            <= 1'b0;
            rd_data_q           <= m_axi_rdata_i;
            rd_valid_q[owner_q] <= 1'b1;
            state_q             <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_done_o       = wr_done_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_data_o       = rd_data_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: controller model, client drivers, scoreboard.
module tb_sdram_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, wr_done, rd_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rd_data, wdata, rdata = '0;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, wvalid, arvalid, rready;
  logic            awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .wr_done_o       (wr_done),
    .rd_valid_o      (rd_valid),
    .rd_data_o       (rd_data),
    .m_axi_awaddr_o  (awaddr),
    .m_axi_awvalid_o (awvalid),
    .m_axi_awready_i (awready),
    .m_axi_wdata_o   (wdata),
    .m_axi_wvalid_o  (wvalid),
    .m_axi_wready_i  (wready),
    .m_axi_araddr_o  (araddr),
    .m_axi_arvalid_o (arvalid),
    .m_axi_arready_i (arready),
    .m_axi_rdata_i   (rdata),
    .m_axi_rvalid_i  (rvalid),
    .m_axi_rready_o  (rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  // SDRAM contents as seen by the controller model; untouched words read as a pattern.
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0] ^ 16'hC3C3;
  endfunction

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) begin
`ifdef SDRAM_ARB_RR_EN
      return last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  // ---------------- controller model ----------------
  int            aw_wait = 0, w_wait = 0, ar_wait = 0, rd_lat = 0;
  logic          ctl_busy = 1'b0;
  int            aw_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr;

  always @(posedge clk) begin
    logic          ar_hs, r_hs;
    logic [AW-1:0] ar_a;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    ar_a  = araddr;
    #1;
    if (rst) begin
      awready = 0; wready = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; ar_cnt = 0; r_cnt = 0; rd_pend = 0;
    end else begin
      if (awvalid && wvalid && !ctl_busy) begin
        awready = (aw_cnt >= aw_wait);
        wready  = (aw_cnt >= w_wait);
        aw_cnt++;
      end else begin
        awready = 0; wready = 0; aw_cnt = 0;
      end
      if (arvalid && !ctl_busy) begin
        arready = (ar_cnt >= ar_wait);
        ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
      if (r_hs) rvalid = 0;
      if (ar_hs) begin
        rd_pend = 1; r_cnt = 0; rd_addr = ar_a;
      end
      if (rd_pend) begin
        if (r_cnt >= rd_lat) begin
          rvalid = 1; rdata = mem_rd(rd_addr); rd_pend = 0;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  txn_t          sb[$];
  int            grant_log[$];
  logic          last_owner = 1'b1;
  logic          rst_pending = 1'b0;
  logic [DW-1:0] last_rd = '0;
  int            acc_cnt[2] = '{0, 0};
  int            wr_done_seen[2] = '{0, 0};
  int            rd_valid_seen[2] = '{0, 0};
  int            aw_hs_cnt = 0, aw_run = 0, last_aw_len = 0;
  logic          prev_aw = 0, prev_aw_hs = 0, prev_ar = 0, prev_ar_hs = 0;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    txn_t       t;
    logic [1:0] exp_rdy;
    logic       aw_hs, ar_hs;
    if (rst) begin
      sb.delete();
      last_owner  = 1'b1;
      rst_pending = 1'b1;
      prev_aw = 0; prev_ar = 0; aw_run = 0;
    end else begin
      if (rst_pending) begin
        check_eq("reset_ctrl", {wr_done, rd_valid, awvalid, wvalid, arvalid, rready}, 0);
        check_eq("reset_data", {rd_data, awaddr, wdata}, 0);
        check_eq("reset_araddr", araddr, 0);
        rst_pending = 1'b0;
        last_rd     = '0;
      end
      check_eq("aw_ar_exclusive", awvalid && arvalid, 0);
      check_eq("ready_onehot0", req_ready == 2'b11, 0);
      if (rd_valid == 2'b00) check_eq("rd_data_hold", rd_data, last_rd);
      if (prev_aw && !prev_aw_hs)
        check_eq("aw_hold", {awvalid, wvalid, awaddr, wdata}, {2'b11, prev_awaddr, prev_wdata});
      if (prev_ar && !prev_ar_hs)
        check_eq("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});

      if (wr_done != 0 || rd_valid != 0) begin
        check_eq("done_exclusive", (wr_done != 0) && (rd_valid != 0), 0);
        for (int p = 0; p < 2; p++) begin
          if (wr_done[p]) wr_done_seen[p]++;
          if (rd_valid[p]) rd_valid_seen[p]++;
        end
        if (sb.size() == 0) begin
          check_eq("unexpected_done", {wr_done, rd_valid}, 0);
        end else begin
          t = sb.pop_front();
          if (t.we) begin
            check_eq("wr_done", {wr_done, rd_valid}, {2'b01 << t.owner, 2'b00});
          end else begin
            check_eq("rd_valid", {wr_done, rd_valid}, {2'b00, 2'b01 << t.owner});
            check_eq("rd_data", rd_data, t.data);
          end
        end
        if (rd_valid != 0) last_rd = rd_data;
      end

      aw_hs = awvalid && wvalid && awready && wready;
      ar_hs = arvalid && arready;
      if (awvalid) aw_run++;
      if (aw_hs) begin
        aw_hs_cnt++;
        last_aw_len = aw_run;
        aw_run      = 0;
        if (sb.size() == 0) begin
          check_eq("unexpected_aw", awvalid, 0);
        end else begin
          check_eq("aw_is_write", sb[0].we, 1);
          check_eq("awaddr", awaddr, sb[0].addr);
          check_eq("wdata", wdata, sb[0].data);
        end
        mem[awaddr] = wdata;
      end
      if (ar_hs) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_ar", arvalid, 0);
        end else begin
          check_eq("ar_is_read", sb[0].we, 0);
          check_eq("araddr", araddr, sb[0].addr);
        end
      end

      if (req_valid != 0) begin
        exp_rdy = (sb.size() != 0) ? 2'b00 : model_grant(req_valid, last_owner);
        check_eq("req_ready", req_ready, exp_rdy);
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          t.owner = p[0];
          t.we    = req_we[p];
          t.addr  = req_addr[p*AW +: AW];
          t.data  = req_we[p] ? req_wdata[p*DW +: DW] : mem_rd(req_addr[p*AW +: AW]);
          sb.push_back(t);
          grant_log.push_back(p);
          last_owner = p[0];
          acc_cnt[p]++;
        end
      end

      prev_aw = awvalid; prev_aw_hs = aw_hs; prev_awaddr = awaddr; prev_wdata = wdata;
      prev_ar = arvalid; prev_ar_hs = ar_hs; prev_araddr = araddr;
    end
  end

  // ---------------- client drivers ----------------
  req_t q0[$], q1[$];
  int   seen[2] = '{0, 0};
  int   cli_rate = 100;

  task automatic tick();
    req_t r;
    @(posedge clk);
    #2;
    for (int p = 0; p < 2; p++) begin
      if (acc_cnt[p] != seen[p]) begin
        seen[p]      = acc_cnt[p];
        req_valid[p] = 1'b0;
      end
      if (!req_valid[p] && $urandom_range(0, 99) < cli_rate &&
          ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0))) begin
        if (p == 0) r = q0.pop_front();
        else        r = q1.pop_front();
        req_valid[p]           = 1'b1;
        req_we[p]              = r.we;
        req_addr[p*AW +: AW]   = r.addr;
        req_wdata[p*DW +: DW]  = r.data;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req_valid != 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, sb.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b0, b1, ok;
    logic [AW-1:0] a;
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: port 1 write held until joint ready
    aw_wait = 2; w_wait = 2;
    b1 = wr_done_seen[1];
    q1.push_back('{we: 1'b1, addr: 25'h0000123, data: 16'hBEEF});
    wait_quiet("t1", 100);
    check_eq("t1_wr_done_p1", wr_done_seen[1] - b1, 1);
    check_eq("t1_mem", mem_rd(25'h0000123), 16'hBEEF);

    // 2: port 0 read, data returned two cycles after the address handshake
    aw_wait = 0; w_wait = 0; ar_wait = 0; rd_lat = 2;
    q1.push_back('{we: 1'b1, addr: 25'h1800400, data: 16'h5A5A});
    wait_quiet("t2w", 100);
    b0 = rd_valid_seen[0];
    q0.push_back('{we: 1'b0, addr: 25'h1800400, data: 16'h0});
    wait_quiet("t2", 100);
    check_eq("t2_rd_valid_p0", rd_valid_seen[0] - b0, 1);
    check_eq("t2_rd_data", rd_data, 16'h5A5A);

    // 3: contention after reset
    pulse_reset();
    base = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b0, addr: 25'(i), data: 16'h0});
      q1.push_back('{we: 1'b0, addr: 25'(i + 16), data: 16'h0});
    end
    wait_quiet("t3", 400);
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_RR_EN
      check_eq($sformatf("t3_grant%0d", i), grant_log[base + i], i % 2);
`else
      check_eq($sformatf("t3_grant%0d", i), grant_log[base + i], 0);
`endif
    end

    // 4: address ready early, data ready five cycles late
    aw_wait = 0; w_wait = 5;
    b0 = wr_done_seen[0];
    q0.push_back('{we: 1'b1, addr: 25'h0ABCDEF, data: 16'h1234});
    wait_quiet("t4", 100);
    check_eq("t4_aw_len", last_aw_len, 6);
    check_eq("t4_wr_done_p0", wr_done_seen[0] - b0, 1);
    w_wait = 0;

    // 5: reset while waiting for read data
    rd_lat = 20;
    b0 = rd_valid_seen[0];
    q0.push_back('{we: 1'b0, addr: 25'h0000055, data: 16'h0});
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (rready) ok = 1;
    end
    check_eq("t5_reached_rd", ok, 1);
    pulse_reset();
    repeat (30) tick();
    check_eq("t5_no_rd_valid", rd_valid_seen[0] - b0, 0);
    rd_lat = 3;
    q0.push_back('{we: 1'b0, addr: 25'h0000055, data: 16'h0});
    wait_quiet("t5b", 100);
    check_eq("t5_rd_after_reset", rd_valid_seen[0] - b0, 1);

    // 6: controller busy for 20000 cycles after reset
    ctl_busy = 1'b1;
    pulse_reset();
    base = aw_hs_cnt;
    b1 = wr_done_seen[1];
    q1.push_back('{we: 1'b1, addr: 25'h0F00F00, data: 16'hCAFE});
    repeat (20000) tick();
    check_eq("t6_stalled", aw_hs_cnt - base, 0);
    ctl_busy = 1'b0;
    wait_quiet("t6", 100);
    check_eq("t6_aw_once", aw_hs_cnt - base, 1);
    check_eq("t6_wr_done_p1", wr_done_seen[1] - b1, 1);

    // random traffic on both ports
    cli_rate = 60;
    base = acc_cnt[0] + acc_cnt[1];
    b0 = wr_done_seen[0] + wr_done_seen[1] + rd_valid_seen[0] + rd_valid_seen[1];
    repeat (1500) begin
      a = '0;
      a[24:23] = 2'($urandom_range(0, 3));
      a[3:0]   = 4'($urandom_range(0, 15));
      if (q0.size() < 2 && $urandom_range(0, 3) == 0)
        q0.push_back('{we: 1'($urandom), addr: a, data: 16'($urandom)});
      a[9:8] = 2'($urandom_range(0, 3));
      if (q1.size() < 2 && $urandom_range(0, 3) == 0)
        q1.push_back('{we: 1'($urandom), addr: a, data: 16'($urandom)});
      if ($urandom_range(0, 7) == 0) begin
        aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
        ar_wait = $urandom_range(0, 3); rd_lat = $urandom_range(0, 4);
      end
      tick();
    end
    wait_quiet("rand", 2000);
    check_eq("rand_all_completed",
             wr_done_seen[0] + wr_done_seen[1] + rd_valid_seen[0] + rd_valid_seen[1] - b0,
             acc_cnt[0] + acc_cnt[1] - base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
